lut_prog: RTL and testbench

- Programmable, parametrised pointer lookup table for data-memory addressing.
- Holds DEPTH entries of WIDTH-bit addresses. A narrow pointer selects an entry, which is returned one cycle later as a data-memory address.
- Entries are rewritable at run time. An optional post-increment lets one entry walk through memory (string/array scans) without spending ALU instructions.
- Sits between instruction decode (supplies ptr_i and control) and the data-memory address mux.

---
 rtl/lut_prog.sv | 94 +++++++++
 tb/tb_lut_prog.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/lut_prog.sv
// Programmable pointer lookup table feeding the data-memory address mux.
// Flop-based entries with 1-cycle registered read, run-time writes and optional post-increment.
module lut_prog #(
  parameter int unsigned                 WIDTH  = 8,
  parameter int unsigned                 DEPTH  = 32,
  parameter int unsigned                 PTR_W  = 5,
  parameter int unsigned                 STRIDE = 1,
  parameter logic [DEPTH*WIDTH-1:0]      INIT   = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PTR_W-1:0] ptr_i,
  input  logic             rd_en_i,
  input  logic             inc_i,
  input  logic             wr_en_i,
  input  logic [PTR_W-1:0] wr_ptr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0] dm_o,
  output logic             dm_valid_o,
  output logic             oob_o
);

  if (DEPTH > (1 << PTR_W) || WIDTH < 1) begin : g_param_err
    $error("lut_prog: DEPTH must be <= 2**PTR_W and WIDTH must be >= 1");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] dm_q, dm_d;
  logic             dm_valid_q, dm_valid_d;
  logic             oob_q, oob_d;

  logic [WIDTH-1:0] rd_val;
  logic             rd_hit;
  logic             wr_hit;

  // Pointer decode by comparison so out-of-range pointers simply match nothing.
  always_comb begin
    rd_val = '0;
    rd_hit = 1'b0;
    wr_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ptr_i == PTR_W'(i)) begin
        rd_val = mem_q[i];
        rd_hit = 1'b1;
      end
      if (wr_ptr_i == PTR_W'(i)) begin
        wr_hit = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      // Write takes priority over a same-index increment.
      if (wr_en_i && (wr_ptr_i == PTR_W'(i))) begin
        mem_d[i] = wr_data_i;
      end else if (rd_en_i && inc_i && (ptr_i == PTR_W'(i))) begin
        mem_d[i] = mem_q[i] + WIDTH'(STRIDE);
      end
    end

    dm_d       = dm_q;
    dm_valid_d = rd_en_i;
    if (rd_en_i) begin
      dm_d = rd_val;
    end
    oob_d = (rd_en_i && !rd_hit) || (wr_en_i && !wr_hit);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= INIT[i*WIDTH +: WIDTH];
      end
      dm_q       <= '0;
      dm_valid_q <= 1'b0;
      oob_q      <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      dm_q       <= dm_d;
      dm_valid_q <= dm_valid_d;
      oob_q      <= oob_d;
    end
  end

  assign dm_o       = dm_q;
  assign dm_valid_o = dm_valid_q;
  assign oob_o      = oob_q;

endmodule

// File: tb/tb_lut_prog.sv
// Directed bench for lut_prog: 10-entry, 8-bit table with a 5-bit pointer.
module tb_lut_prog;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned DEPTH  = 10;
  localparam int unsigned PTR_W  = 5;
  localparam int unsigned STRIDE = 1;
  localparam logic [DEPTH*WIDTH-1:0] INIT = {8'd9, 8'd200, 8'd32, 8'd0, 8'd255,
                                             8'd15, 8'd66, 8'd127, 8'd20, 8'd14};

  logic             clk = 1'b0;
  logic             reset;
  logic [PTR_W-1:0] ptr_i;
  logic             rd_en_i;
  logic             inc_i;
  logic             wr_en_i;
  logic [PTR_W-1:0] wr_ptr_i;
  logic [WIDTH-1:0] wr_data_i;
  logic [WIDTH-1:0] dm_o;
  logic             dm_valid_o;
  logic             oob_o;

  int total = 0;
  int bad   = 0;

  lut_prog #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .STRIDE(STRIDE),
    .INIT  (INIT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ptr_i     (ptr_i),
    .rd_en_i   (rd_en_i),
    .inc_i     (inc_i),
    .wr_en_i   (wr_en_i),
    .wr_ptr_i  (wr_ptr_i),
    .wr_data_i (wr_data_i),
    .dm_o      (dm_o),
    .dm_valid_o(dm_valid_o),
    .oob_o     (oob_o)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic rd(input int p, input logic inc);
    rd_en_i = 1'b1;
    ptr_i   = PTR_W'(p);
    inc_i   = inc;
    cycle();
  endtask

  int exp_tab [DEPTH] = '{14, 20, 127, 66, 18, 1, 0, 100, 200, 9};

  initial begin
    reset = 1'b1; ptr_i = '0; rd_en_i = 1'b0; inc_i = 1'b0;
    wr_en_i = 1'b0; wr_ptr_i = '0; wr_data_i = '0;
    cycle();
    cycle();
    reset = 1'b0;
    chk("reset_dm", 32'(dm_o), 0);
    chk("reset_valid", 32'(dm_valid_o), 0);
    chk("reset_oob", 32'(oob_o), 0);

    // Consecutive reads of the reset image
    rd(0, 1'b0); chk("rd0", 32'(dm_o), 14); chk("rd0_valid", 32'(dm_valid_o), 1);
    rd(1, 1'b0); chk("rd1", 32'(dm_o), 20); chk("rd1_valid", 32'(dm_valid_o), 1);
    rd(2, 1'b0); chk("rd2", 32'(dm_o), 127); chk("rd2_valid", 32'(dm_valid_o), 1);
    rd_en_i = 1'b0;
    cycle();
    chk("idle_valid", 32'(dm_valid_o), 0);
    chk("idle_hold", 32'(dm_o), 127);

    // Post-increment scan of entry 4
    rd(4, 1'b1); chk("inc4_a", 32'(dm_o), 15);
    rd(4, 1'b1); chk("inc4_b", 32'(dm_o), 16);
    rd(4, 1'b1); chk("inc4_c", 32'(dm_o), 17);
    rd(4, 1'b0); chk("inc4_plain", 32'(dm_o), 18);

    // Wrap-around of entry 5
    rd(5, 1'b1); chk("wrap_a", 32'(dm_o), 255);
    rd(5, 1'b1); chk("wrap_b", 32'(dm_o), 0);
    chk("wrap_oob", 32'(oob_o), 0);

    // Write and increment colliding on entry 7
    wr_en_i = 1'b1; wr_ptr_i = 5'd7; wr_data_i = 8'd100;
    rd(7, 1'b1); chk("coll_old", 32'(dm_o), 32);
    wr_en_i = 1'b0;
    rd(7, 1'b0); chk("coll_new", 32'(dm_o), 100);

    // Out-of-range read with increment, then out-of-range write
    rd(12, 1'b1);
    chk("oob_rd_dm", 32'(dm_o), 0);
    chk("oob_rd_valid", 32'(dm_valid_o), 1);
    chk("oob_rd_flag", 32'(oob_o), 1);
    rd_en_i = 1'b0; inc_i = 1'b0;
    wr_en_i = 1'b1; wr_ptr_i = 5'd31; wr_data_i = 8'd9;
    cycle();
    chk("oob_wr_flag", 32'(oob_o), 1);
    chk("oob_wr_valid", 32'(dm_valid_o), 0);
    wr_en_i = 1'b0;
    cycle();
    chk("oob_clear", 32'(oob_o), 0);
    for (int i = 0; i < DEPTH; i++) begin
      rd(i, 1'b0);
      chk($sformatf("readback%0d", i), 32'(dm_o), 32'(exp_tab[i]));
    end

    // Reset in the middle of a scan restores INIT
    for (int i = 0; i < 5; i++) begin
      rd(4, 1'b1);
      chk($sformatf("scan%0d", i), 32'(dm_o), 32'(18 + i));
    end
    reset = 1'b1;
    rd(4, 1'b1);
    reset = 1'b0;
    chk("mid_rst_valid", 32'(dm_valid_o), 0);
    chk("mid_rst_oob", 32'(oob_o), 0);
    chk("mid_rst_dm", 32'(dm_o), 0);
    rd(4, 1'b0); chk("mid_rst_e4", 32'(dm_o), 15);
    rd(7, 1'b0); chk("mid_rst_e7", 32'(dm_o), 32);
    rd(5, 1'b0); chk("mid_rst_e5", 32'(dm_o), 255);
    rd_en_i = 1'b0;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
